// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the divider's state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/big_cla.sv
// Parallel-prefix (Kogge-Stone) carry-lookahead adder: sum = a + b + cin.
module big_cla #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LVL = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [LVL:0][WIDTH-1:0] w_g;
  logic [LVL:0][WIDTH-1:0] w_p;
  logic [WIDTH:0]          w_c;

  // Level l combines each bit's group with the group 2^l positions below it.
  always_comb begin
    w_g    = '0;
    w_p    = '0;
    w_c    = '0;
    w_g[0] = a & b;
    w_p[0] = a ^ b;
    for (int l = 0; l < LVL; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        int s;
        int j;
        s = 1 << l;
        j = (i >= s) ? (i - s) : 0;
        if (i >= s) begin
          w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][j]);
          w_p[l+1][i] = w_p[l][i] & w_p[l][j];
        end else begin
          w_g[l+1][i] = w_g[l][i];
          w_p[l+1][i] = w_p[l][i];
        end
      end
    end
    w_c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_c[i+1] = w_g[LVL][i] | (w_p[LVL][i] & cin);
    end
  end

  assign sum  = w_p[0] ^ w_c[WIDTH-1:0];
  assign cout = w_c[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, trial
// subtraction done by big_cla as shifted + ~divisor + 1.
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_div;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_r;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic               r_dbz;

  logic               w_msb;
  logic [WIDTH-1:0]   w_shifted;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_accept;
  logic [WIDTH-1:0]   w_r_nxt;
  logic [WIDTH-1:0]   w_q_nxt;
  logic               w_last;
  logic               w_div_zero;
  logic               w_accept_run;

  // Trial subtraction: shifted - divisor via the adder in the inverse direction.
  assign w_msb     = r_r[WIDTH-1];
  assign w_shifted = {r_r[WIDTH-2:0], r_q[WIDTH-1]};

  big_cla #(
    .WIDTH (WIDTH)
  ) u_cla (
    .a    (w_shifted),
    .b    (~r_div),
    .cin  (1'b1),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // A set msb means the 33-bit partial remainder already exceeds the divisor.
  assign w_accept     = w_msb | w_cout;
  assign w_r_nxt      = w_accept ? w_sum : w_shifted;
  assign w_q_nxt      = {r_q[WIDTH-2:0], w_accept};
  assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_div_zero   = (divisor == '0);
  assign w_accept_run = (r_state == IDLE) && start && !w_div_zero;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = w_div_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && start) begin
        r_cnt <= '0;
        if (w_div_zero) begin
          r_quot <= '1;
          r_rem  <= dividend;
          r_dbz  <= 1'b1;
        end else begin
          r_dbz  <= 1'b0;
        end
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_quot <= w_q_nxt;
          r_rem  <= w_r_nxt;
        end
      end
    end
  end

  // Working registers carry no reset: they are always loaded before use.
  always_ff @(posedge clk) begin
    if (w_accept_run) begin
      r_div <= divisor;
      r_q   <= dividend;
      r_r   <= '0;
    end else if (r_state == RUN) begin
      r_q <= w_q_nxt;
      r_r <= w_r_nxt;
    end
  end

  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Issue one divide and wait (bounded) for done; n = negedges after accept.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int n, output int bcnt,
                         output bit overlap);
    n = 0; bcnt = 0; overlap = 0; q = '0; r = '0; z = 1'b0;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= W + 20; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (busy && done) overlap = 1;
      if (done) begin
        n = k; q = quotient; r = remainder; z = div_by_zero;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '1; divisor = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl got busy/done/dbz=%b%b%b exp 000", busy, done, div_by_zero);
    end
    total++;
    if ({quotient, remainder} !== '0) begin
      bad++;
      $display("FAIL reset_data got q=%h r=%h exp 0/0", quotient, remainder);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] q, r; logic z; int n, bc; bit ov;
    run_div(32'd100, 32'd7, q, r, z, n, bc, ov);
    total++;
    if (n !== W + 1) begin bad++; $display("FAIL basic_latency got %0d exp %0d", n, W + 1); end
    total++;
    if (bc !== W) begin bad++; $display("FAIL basic_busy_cycles got %0d exp %0d", bc, W); end
    total++;
    if (ov !== 1'b0) begin bad++; $display("FAIL basic_busy_done_overlap got %0d exp 0", ov); end
    total++;
    if ({q, r, z} !== {32'd14, 32'd2, 1'b0}) begin
      bad++;
      $display("FAIL basic_100_7 got q=%0d r=%0d z=%0d exp q=14 r=2 z=0", q, r, z);
    end
    @(negedge clk);
    total++;
    if ({done, busy, quotient, remainder} !== {1'b0, 1'b0, 32'd14, 32'd2}) begin
      bad++;
      $display("FAIL basic_hold got done=%0d busy=%0d q=%0d r=%0d exp 0 0 14 2",
               done, busy, quotient, remainder);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic [W-1:0] q, r, eq, er; logic z, ez; int n, bc; bit ov;
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h0000_0001;
    ta[1] = 32'hFFFF_FFFF; tb[1] = 32'h8000_0000;
    ta[2] = 32'h8000_0000; tb[2] = 32'hFFFF_FFFF;
    ta[3] = 32'h0000_0000; tb[3] = 32'h0000_0009;
    for (int i = 0; i < 4; i++) begin
      run_div(ta[i], tb[i], q, r, z, n, bc, ov);
      ref_div(ta[i], tb[i], eq, er, ez);
      total++;
      if ({q, r, z} !== {eq, er, ez}) begin
        bad++;
        $display("FAIL boundary_%0d %h/%h got q=%h r=%h z=%0d exp q=%h r=%h z=%0d",
                 i, ta[i], tb[i], q, r, z, eq, er, ez);
      end
      total++;
      if (n !== W + 1) begin bad++; $display("FAIL boundary_%0d_latency got %0d exp %0d", i, n, W + 1); end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r; logic z; int n, bc; bit ov;
    run_div(32'd5, 32'd0, q, r, z, n, bc, ov);
    total++;
    if (n !== 1) begin bad++; $display("FAIL dbz_latency got %0d exp 1", n); end
    total++;
    if (bc !== 0) begin bad++; $display("FAIL dbz_busy got %0d cycles exp 0", bc); end
    total++;
    if ({q, r, z} !== {32'hFFFF_FFFF, 32'd5, 1'b1}) begin
      bad++;
      $display("FAIL dbz_result got q=%h r=%0d z=%0d exp q=ffffffff r=5 z=1", q, r, z);
    end
    run_div(32'd9, 32'd3, q, r, z, n, bc, ov);
    total++;
    if ({q, r, z} !== {32'd3, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL dbz_then_9_3 got q=%0d r=%0d z=%0d exp q=3 r=0 z=0", q, r, z);
    end
  endtask

  task automatic test_start_held();
    logic [W-1:0] a, b, c, d, eq, er; logic ez; int n;
    a = $urandom; b = $urandom | 32'h1;
    c = $urandom; d = $urandom_range(1, 1000);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    n = 0;
    for (int k = 1; k <= W + 20; k++) begin
      @(negedge clk);
      if (done) begin n = k; break; end
      dividend = $urandom;
      divisor  = $urandom;
    end
    ref_div(a, b, eq, er, ez);
    total++;
    if (n !== W + 1) begin bad++; $display("FAIL held_latency got %0d exp %0d", n, W + 1); end
    total++;
    if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
      bad++;
      $display("FAIL held_result got q=%h r=%h exp q=%h r=%h", quotient, remainder, eq, er);
    end
    dividend = c; divisor = d;
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL held_after_done got busy/done=%b%b exp 00", busy, done);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL held_reaccept got busy=%0d exp 1", busy); end
    start = 1'b0; dividend = $urandom; divisor = 32'd0;
    n = 0;
    for (int k = 1; k <= W + 20; k++) begin
      @(negedge clk);
      if (done) begin n = k; break; end
    end
    ref_div(c, d, eq, er, ez);
    total++;
    if (n === 0 || {quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
      bad++;
      $display("FAIL held_second got q=%h r=%h z=%0d exp q=%h r=%h z=%0d (done at %0d)",
               quotient, remainder, div_by_zero, eq, er, ez, n);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q, r; logic z; int n, bc, dcnt; bit ov;
    @(negedge clk);
    dividend = 32'd100000; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      bad++;
      $display("FAIL midreset_clear got busy=%0d done=%0d z=%0d q=%h r=%h exp all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    total++;
    if (dcnt !== 0) begin bad++; $display("FAIL midreset_no_done got %0d active cycles exp 0", dcnt); end
    run_div(32'd1000, 32'd33, q, r, z, n, bc, ov);
    total++;
    if ({q, r, z} !== {32'd30, 32'd10, 1'b0}) begin
      bad++;
      $display("FAIL midreset_1000_33 got q=%0d r=%0d z=%0d exp q=30 r=10 z=0", q, r, z);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r, eq, er; logic z, ez; int n, bc, en; bit ov;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 255);
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_div(a, b, q, r, z, n, bc, ov);
      ref_div(a, b, eq, er, ez);
      en = (b == '0) ? 1 : W + 1;
      total++;
      if ({q, r, z} !== {eq, er, ez}) begin
        bad++;
        $display("FAIL random_%0d %h/%h got q=%h r=%h z=%0d exp q=%h r=%h z=%0d",
                 i, a, b, q, r, z, eq, er, ez);
      end
      total++;
      if (n !== en || ov !== 1'b0) begin
        bad++;
        $display("FAIL random_%0d_timing got done at %0d overlap=%0d exp %0d overlap=0",
                 i, n, ov, en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider for the ALU datapath. Computes a WIDTH-bit quotient and remainder from a start pulse, one quotient bit per clock. Each trial subtraction runs through the existing `big_cla` adder as a + ~b + 1, so the adder is used in the inverse direction. It sits beside the combinational ALU units and gives the ALU its only multi-cycle operation, with a start/busy/done handshake.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width. Must equal the `big_cla` width.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request; sampled only in IDLE.
- `dividend` input, WIDTH bits: unsigned dividend; captured on the accepting edge.
- `divisor` input, WIDTH bits: unsigned divisor; captured on the accepting edge.
- `busy` output, 1 bit: iteration in progress.
- `done` output, 1 bit: one-cycle pulse; results valid.
- `quotient` output, WIDTH bits: held from done until the next accepted start.
- `remainder` output, WIDTH bits: held from done until the next accepted start.
- `div_by_zero` output, 1 bit: qualifies the current results; held with them.

## Operation
- States: IDLE, RUN, DONE.
- Reset (`rst`=1 at an edge) forces IDLE, counter 0, and `busy`, `done`, `quotient`, `remainder`, `div_by_zero` all to 0.
- `rst` wins over every other input. A reset mid-RUN abandons the operation with no `done`.
- IDLE, `start`=1, divisor≠0:
  - latch divisor; Q register ← dividend; R register ← 0; counter ← 0; `div_by_zero` ← 0; → RUN.
- IDLE, `start`=1, divisor=0:
  - `quotient` ← all ones; `remainder` ← dividend; `div_by_zero` ← 1; → DONE.
- RUN, one iteration per edge:
  - msb = R[WIDTH-1]; shifted = {R[WIDTH-2:0], Q[WIDTH-1]}.
  - `big_cla` computes shifted + ~divisor + 1; its carry-out is cout.
  - accept = msb | cout. When msb=1, the 33-bit value exceeds the divisor and the low WIDTH bits of the sum are the exact difference.
  - R ← accept ? sum : shifted; Q ← {Q[WIDTH-2:0], accept}; counter++.
  - On the iteration with counter = WIDTH-1: copy Q and R to `quotient`/`remainder`; → DONE.
- DONE: `done`=1 for this cycle only; → IDLE unconditionally.
- `start` in RUN or DONE is ignored; operands are not re-latched.
- Input changes after the accepting edge have no effect.

## Timing
- `busy`=1 exactly while in RUN; `done`=1 exactly while in DONE; never both high.
- Accepting edge E0, normal divide:
  - `busy` high after E0 through E32;
  - `done` high for the one cycle after E32;
  - earliest next accept at E34 (start held high at E33 is ignored).
- Divide by zero: `done` high for the cycle after E0; `busy` never asserted.
- Latency in general: WIDTH cycles from accept to `done`; 1 cycle for divide by zero.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `alu_pkg` holds the default WIDTH constant and the state typedef/encoding (IDLE, RUN, DONE).
- One sub-module, an instance of the existing `big_cla`:
  - a = shifted, b = ~divisor, cin = 1;
  - its sum and cout feed the accept logic.
- Counter width is $clog2(WIDTH+1).

## Test plan
- 100 / 7: `done` exactly 32 cycles after accept; q=14, r=2, dbz=0; `busy` high for exactly those 32 cycles.
- 0xFFFFFFFF / 1 gives q=0xFFFFFFFF, r=0. 0xFFFFFFFF / 0x80000000 gives q=1, r=0x7FFFFFFF (exercises the msb accept path).
- 0x80000000 / 0xFFFFFFFF gives q=0, r=0x80000000. 0 / 9 gives q=0, r=0.
- 5 / 0: `done` on the cycle after accept with q=0xFFFFFFFF, r=5, dbz=1; `busy` stays 0. Next divide 9/3 gives q=3, r=0, dbz=0.
- `start` held high continuously with new operands applied during RUN: results are those of the operands latched at accept; the next accept occurs the cycle after `done`.
- `rst` asserted at iteration 10: the next cycle shows all outputs 0 and IDLE, with no `done` pulse. A following 1000 / 33 gives q=30, r=10.
